// File: rtl/fetch_redirect_controller.sv
// Front-end fetch PC sequencer with prioritised redirect arbitration.
// Stalls on unresolved JALR and drains the front end after ROB flushes.
module fetch_redirect_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_ready,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        dec_jal_valid,
  input  logic [31:0] dec_jal_target,
  input  logic        dec_jalr_valid,
  input  logic        jalr_resolve_valid,
  input  logic [31:0] jalr_target,
  input  logic        rob_redirect_valid,
  input  logic [31:0] rob_redirect_pc,
  output logic [31:0] pc_out,
  output logic        fetch_en,
  output logic        fetch_squash,
  output logic        flush_out,
  output logic [1:0]  state_out,
  output logic [15:0] mispredict_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] ALIGN = ~32'h1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  drain_q, drain_d;
  logic        squash_q, squash_d;
  logic        flush_q, flush_d;
  logic [15:0] mcnt_q, mcnt_d;

  // Next-state: one action per cycle, highest priority request wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drain_d  = drain_q;
    mcnt_d   = mcnt_q;
    squash_d = 1'b0;
    flush_d  = 1'b0;
    if (rdy_in) begin
      if (rob_redirect_valid) begin
        pc_d     = rob_redirect_pc & ALIGN;
        flush_d  = 1'b1;
        squash_d = 1'b1;
        drain_d  = DRAIN_INIT;
        state_d  = FLUSH;
        if (mcnt_q != 16'hFFFF)
          mcnt_d = mcnt_q + 16'd1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (dec_jalr_valid) begin
              state_d = STALL;
            end else if (dec_jal_valid) begin
              pc_d     = dec_jal_target & ALIGN;
              squash_d = 1'b1;
            end else if (fetch_ready) begin
              pc_d = pred_taken ? (pred_target & ALIGN)
                                : pc_q + 32'd4;
            end
          end
          STALL: begin
            if (jalr_resolve_valid) begin
              pc_d    = jalr_target & ALIGN;
              state_d = RUN;
            end
          end
          FLUSH: begin
            if (drain_q == 4'd0)
              state_d = RUN;
            else
              drain_d = drain_q - 4'd1;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  // State, PC, drain counter, pulses and mispredict count registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      drain_q  <= 4'd0;
      squash_q <= 1'b0;
      flush_q  <= 1'b0;
      mcnt_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drain_q  <= drain_d;
      squash_q <= squash_d;
      flush_q  <= flush_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign fetch_en       = rdy_in && (state_q == RUN);
  assign fetch_squash   = squash_q;
  assign flush_out      = flush_q;
  assign state_out      = state_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Scoreboard bench for fetch_redirect_controller.
// Expected cycle results are queued at drive time and checked after the edge.
module tb_fetch_redirect_controller;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        dec_jal_valid = 1'b0;
  logic [31:0] dec_jal_target = '0;
  logic        dec_jalr_valid = 1'b0;
  logic        jalr_resolve_valid = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        rob_redirect_valid = 1'b0;
  logic [31:0] rob_redirect_pc = '0;
  logic [31:0] pc_out;
  logic        fetch_en;
  logic        fetch_squash;
  logic        flush_out;
  logic [1:0]  state_out;
  logic [15:0] mispredict_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        fen;
    logic        sq;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  fetch_redirect_controller #(
    .RESET_PC(32'h0),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .fetch_ready(fetch_ready),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .dec_jal_valid(dec_jal_valid),
    .dec_jal_target(dec_jal_target),
    .dec_jalr_valid(dec_jalr_valid),
    .jalr_resolve_valid(jalr_resolve_valid),
    .jalr_target(jalr_target),
    .rob_redirect_valid(rob_redirect_valid),
    .rob_redirect_pc(rob_redirect_pc),
    .pc_out(pc_out),
    .fetch_en(fetch_en),
    .fetch_squash(fetch_squash),
    .flush_out(flush_out),
    .state_out(state_out),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Queue expectation, clock once, then pop and compare every output.
  task automatic tick(input string name, input logic [31:0] pc,
                      input logic [1:0] st, input logic sq,
                      input logic fl, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.pc = pc; e.st = st;
    e.fen = rdy_in && (st == 2'd0);
    e.sq = sq; e.fl = fl; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    dec_jal_valid = 1'b0;
    dec_jalr_valid = 1'b0;
    jalr_resolve_valid = 1'b0;
    rob_redirect_valid = 1'b0;
    e = sb.pop_front();
    checks += 6;
    if (pc_out !== e.pc) begin
      errors++;
      $display("FAIL %s.pc got %h want %h", e.name, pc_out, e.pc);
    end
    if (state_out !== e.st) begin
      errors++;
      $display("FAIL %s.state got %0d want %0d", e.name, state_out, e.st);
    end
    if (fetch_en !== e.fen) begin
      errors++;
      $display("FAIL %s.fetch_en got %b want %b", e.name, fetch_en, e.fen);
    end
    if (fetch_squash !== e.sq) begin
      errors++;
      $display("FAIL %s.squash got %b want %b", e.name, fetch_squash, e.sq);
    end
    if (flush_out !== e.fl) begin
      errors++;
      $display("FAIL %s.flush got %b want %b", e.name, flush_out, e.fl);
    end
    if (mispredict_cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s.cnt got %h want %h", e.name, mispredict_cnt, e.cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL rst.pc got %h want 0", pc_out);
    end
    if (state_out !== 2'd0) begin
      errors++; $display("FAIL rst.state got %0d want 0", state_out);
    end
    if (fetch_squash !== 1'b0 || flush_out !== 1'b0) begin
      errors++;
      $display("FAIL rst.pulses got %b%b want 00", fetch_squash, flush_out);
    end
    if (mispredict_cnt !== 16'h0) begin
      errors++; $display("FAIL rst.cnt got %h want 0", mispredict_cnt);
    end
    if (fetch_en !== 1'b1) begin
      errors++; $display("FAIL rst.fetch_en got %b want 1", fetch_en);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_sequential();
    fetch_ready = 1'b1;
    tick("seq0", 32'h4, 2'd0, 0, 0, 16'd0);
    tick("seq1", 32'h8, 2'd0, 0, 0, 16'd0);
    tick("seq2", 32'hC, 2'd0, 0, 0, 16'd0);
    fetch_ready = 1'b0;
    tick("hold", 32'hC, 2'd0, 0, 0, 16'd0);
  endtask

  task automatic test_predict_jal();
    dec_jal_valid = 1'b1; dec_jal_target = 32'h100;
    tick("jal100", 32'h100, 2'd0, 1, 0, 16'd0);
    fetch_ready = 1'b1;
    pred_taken = 1'b1; pred_target = 32'h200;
    tick("pred", 32'h200, 2'd0, 0, 0, 16'd0);
    pred_taken = 1'b0;
    dec_jal_valid = 1'b1; dec_jal_target = 32'h301;
    tick("jal301", 32'h300, 2'd0, 1, 0, 16'd0);
    tick("postjal", 32'h304, 2'd0, 0, 0, 16'd0);
  endtask

  task automatic test_jalr_stall();
    dec_jal_valid = 1'b1; dec_jal_target = 32'h40;
    tick("jal40", 32'h40, 2'd0, 1, 0, 16'd0);
    dec_jalr_valid = 1'b1;
    tick("jalr", 32'h40, 2'd1, 0, 0, 16'd0);
    for (int i = 0; i < 5; i++)
      tick("stall", 32'h40, 2'd1, 0, 0, 16'd0);
    jalr_resolve_valid = 1'b1; jalr_target = 32'h80;
    tick("resolve", 32'h80, 2'd0, 0, 0, 16'd0);
  endtask

  task automatic test_rob_in_stall();
    dec_jalr_valid = 1'b1;
    tick("jalr2", 32'h80, 2'd1, 0, 0, 16'd0);
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h500;
    jalr_resolve_valid = 1'b1; jalr_target = 32'h900;
    tick("rob500", 32'h500, 2'd2, 1, 1, 16'd1);
    tick("drain1", 32'h500, 2'd2, 0, 0, 16'd1);
    tick("run500", 32'h500, 2'd0, 0, 0, 16'd1);
    fetch_ready = 1'b0;
    tick("idle500", 32'h500, 2'd0, 0, 0, 16'd1);
  endtask

  task automatic test_back_to_back();
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h100;
    tick("rob100", 32'h100, 2'd2, 1, 1, 16'd2);
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h600;
    tick("rob600", 32'h600, 2'd2, 1, 1, 16'd3);
    rdy_in = 1'b0;
    tick("frz0", 32'h600, 2'd2, 0, 0, 16'd3);
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'hA00;
    tick("frz1", 32'h600, 2'd2, 0, 0, 16'd3);
    tick("frz2", 32'h600, 2'd2, 0, 0, 16'd3);
    rdy_in = 1'b1;
    tick("drain2", 32'h600, 2'd2, 0, 0, 16'd3);
    tick("run600", 32'h600, 2'd0, 0, 0, 16'd3);
  endtask

  task automatic test_wrap_reset();
    dec_jal_valid = 1'b1; dec_jal_target = 32'hFFFF_FFFC;
    tick("jalFFC", 32'hFFFF_FFFC, 2'd0, 1, 0, 16'd3);
    fetch_ready = 1'b1;
    tick("wrap", 32'h0, 2'd0, 0, 0, 16'd3);
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h700;
    tick("rob700", 32'h700, 2'd2, 1, 1, 16'd4);
    #2;
    rst_in = 1'b0;
    #1;
    checks += 3;
    if (state_out !== 2'd0) begin
      errors++; $display("FAIL arst.state got %0d want 0", state_out);
    end
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL arst.pc got %h want 0", pc_out);
    end
    if (mispredict_cnt !== 16'h0) begin
      errors++; $display("FAIL arst.cnt got %h want 0", mispredict_cnt);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'h0 || fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL first.fetch got %h/%b want 0/1", pc_out, fetch_en);
    end
  endtask

  task automatic test_saturate();
    @(posedge clk_in);
    #1;
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h800;
    repeat (65535) @(posedge clk_in);
    #1;
    checks++;
    if (mispredict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat.reach got %h want ffff", mispredict_cnt);
    end
    rob_redirect_valid = 1'b1;
    tick("sat", 32'h800, 2'd2, 1, 1, 16'hFFFF);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict_jal();
    test_jalr_stall();
    test_rob_in_stall();
    test_back_to_back();
    test_wrap_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
